// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use bubble insertion and valid/ready flow.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [XLEN-1:0] iv_pc,
  input  logic [XLEN-1:0] iv_imm,
  input  logic [XLEN-1:0] iv_rs1_data,
  input  logic [XLEN-1:0] iv_rs2_data,
  input  logic [RA_W-1:0] iv_rs1_addr,
  input  logic [RA_W-1:0] iv_rs2_addr,
  input  logic [RA_W-1:0] iv_rd_addr,
  input  logic [4:0]      iv_ALUop,
  input  logic            i_use_pc,
  input  logic            i_use_imm,
  input  logic            i_reg_write,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_flush,
  input  logic            i_ex_ready,
  input  logic [RA_W-1:0] iv_mem_rd_addr,
  input  logic [RA_W-1:0] iv_wb_rd_addr,
  input  logic [XLEN-1:0] iv_mem_result,
  input  logic [XLEN-1:0] iv_wb_result,
  input  logic            i_mem_reg_write,
  input  logic            i_wb_reg_write,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] ov_A,
  output logic [XLEN-1:0] ov_B,
  output logic [XLEN-1:0] ov_store_data,
  output logic [4:0]      ov_ALUop,
  output logic [RA_W-1:0] ov_rd_addr,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_load_use
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]     ov_stall_cnt
`endif
);

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  state_e          r_state, w_state_d;
  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_imm, r_rs1_data, r_rs2_data;
  logic [RA_W-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [4:0]      r_aluop;
  logic            r_use_pc, r_use_imm, r_reg_write, r_mem_read, r_mem_write;

  logic            w_adv, w_load_use, w_capture, w_bubble, w_clear;
  logic [XLEN-1:0] w_fwd1, w_fwd2;

  assign w_adv      = !r_valid || i_ex_ready;
  assign w_load_use = r_valid && r_mem_read && i_id_valid && (r_rd_addr != '0) &&
                      ((r_rd_addr == iv_rs1_addr) || (r_rd_addr == iv_rs2_addr));

  // Ready is forced low while reset is asserted, independent of the held state.
  assign o_id_ready = i_rst_n && (i_flush || (w_adv && !w_load_use));
  assign o_load_use = w_load_use;

  always_comb begin
    w_state_d = StRun;
    w_capture = 1'b0;
    w_bubble  = 1'b0;
    w_clear   = 1'b0;
    unique case (r_state)
      StRun: begin
        if (i_flush) begin
          w_clear = 1'b1;
        end else if (w_adv) begin
          if (w_load_use) begin
            w_bubble  = 1'b1;
            w_state_d = StBubble;
          end else if (i_id_valid) begin
            w_capture = 1'b1;
          end else begin
            w_clear = 1'b1;
          end
        end
      end
      StBubble: begin
        // Held entry is the bubble, so the dependent instruction is taken here.
        if (i_flush) begin
          w_clear = 1'b1;
        end else if (w_adv) begin
          if (i_id_valid && !w_load_use) begin
            w_capture = 1'b1;
          end else begin
            w_clear = 1'b1;
          end
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_aluop     <= '0;
      r_use_pc    <= 1'b0;
      r_use_imm   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_capture) begin
      r_valid     <= 1'b1;
      r_pc        <= iv_pc;
      r_imm       <= iv_imm;
      r_rs1_data  <= iv_rs1_data;
      r_rs2_data  <= iv_rs2_data;
      r_rs1_addr  <= iv_rs1_addr;
      r_rs2_addr  <= iv_rs2_addr;
      r_rd_addr   <= iv_rd_addr;
      r_aluop     <= iv_ALUop;
      r_use_pc    <= i_use_pc;
      r_use_imm   <= i_use_imm;
      r_reg_write <= i_reg_write;
      r_mem_read  <= i_mem_read;
      r_mem_write <= i_mem_write;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_clear) begin
      r_valid <= 1'b0;
    end
  end

  // MEM result is younger than WB, so it wins; x0 never forwards.
  assign w_fwd1 = (i_mem_reg_write && (iv_mem_rd_addr == r_rs1_addr) && (r_rs1_addr != '0)) ?
                  iv_mem_result :
                  (i_wb_reg_write && (iv_wb_rd_addr == r_rs1_addr) && (r_rs1_addr != '0)) ?
                  iv_wb_result : r_rs1_data;
  assign w_fwd2 = (i_mem_reg_write && (iv_mem_rd_addr == r_rs2_addr) && (r_rs2_addr != '0)) ?
                  iv_mem_result :
                  (i_wb_reg_write && (iv_wb_rd_addr == r_rs2_addr) && (r_rs2_addr != '0)) ?
                  iv_wb_result : r_rs2_data;

  assign o_ex_valid    = r_valid;
  assign ov_A          = r_use_pc ? r_pc : w_fwd1;
  assign ov_B          = r_use_imm ? r_imm : w_fwd2;
  assign ov_store_data = w_fwd2;
  assign ov_ALUop      = r_aluop;
  assign ov_rd_addr    = r_rd_addr;
  assign o_reg_write   = r_reg_write && r_valid;
  assign o_mem_read    = r_mem_read && r_valid;
  assign o_mem_write   = r_mem_write && r_valid;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_id_valid && !o_id_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign ov_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by a short random run.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  rd;
    logic [4:0]  op;
    logic        use_pc;
    logic        use_imm;
    logic        rw;
    logic        mr;
    logic        mw;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  instr_t      cur = '0;
  logic        id_valid = 1'b0, flush = 1'b0, ex_ready = 1'b1;
  logic [4:0]  mem_rd = '0, wb_rd = '0;
  logic [31:0] mem_res = '0, wb_res = '0;
  logic        mem_we = 1'b0, wb_we = 1'b0;

  logic        id_ready, ex_valid, reg_write, mem_read, mem_write, load_use;
  logic [31:0] out_a, out_b, store_data;
  logic [4:0]  aluop, rd_addr;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_t      sb[$];
  logic        m_valid = 1'b0, m_mr = 1'b0;
  logic [4:0]  m_rd = '0;
  int unsigned m_cnt = 0;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_id_valid     (id_valid),
    .o_id_ready     (id_ready),
    .iv_pc          (cur.pc),
    .iv_imm         (cur.imm),
    .iv_rs1_data    (cur.d1),
    .iv_rs2_data    (cur.d2),
    .iv_rs1_addr    (cur.a1),
    .iv_rs2_addr    (cur.a2),
    .iv_rd_addr     (cur.rd),
    .iv_ALUop       (cur.op),
    .i_use_pc       (cur.use_pc),
    .i_use_imm      (cur.use_imm),
    .i_reg_write    (cur.rw),
    .i_mem_read     (cur.mr),
    .i_mem_write    (cur.mw),
    .i_flush        (flush),
    .i_ex_ready     (ex_ready),
    .iv_mem_rd_addr (mem_rd),
    .iv_wb_rd_addr  (wb_rd),
    .iv_mem_result  (mem_res),
    .iv_wb_result   (wb_res),
    .i_mem_reg_write(mem_we),
    .i_wb_reg_write (wb_we),
    .o_ex_valid     (ex_valid),
    .ov_A           (out_a),
    .ov_B           (out_b),
    .ov_store_data  (store_data),
    .ov_ALUop       (aluop),
    .ov_rd_addr     (rd_addr),
    .o_reg_write    (reg_write),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_load_use     (load_use)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .ov_stall_cnt   (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (mem_we && mem_rd == a && a != 5'd0) return mem_res;
    if (wb_we && wb_rd == a && a != 5'd0) return wb_res;
    return d;
  endfunction

  function automatic instr_t mk(input logic [4:0] a1, input logic [31:0] d1,
                                input logic [4:0] a2, input logic [31:0] d2,
                                input logic [4:0] rd, input logic [4:0] op, input logic ld);
    instr_t x = '0;
    x.pc = 32'h0000_0100;
    x.imm = 32'h0000_0008;
    x.a1 = a1;
    x.d1 = d1;
    x.a2 = a2;
    x.d2 = d2;
    x.rd = rd;
    x.op = op;
    x.rw = 1'b1;
    x.mr = ld;
    x.use_imm = ld;
    return x;
  endfunction

  // Check this cycle's combinational outputs against the reference, then advance the model.
  task automatic eval();
    logic adv, lu, rdy;
    instr_t e;
    adv = !m_valid || ex_ready;
    lu  = m_valid && m_mr && id_valid && (m_rd != 5'd0) && (m_rd == cur.a1 || m_rd == cur.a2);
    rdy = flush || (adv && !lu);
    check_eq("id_ready", {31'd0, id_ready}, {31'd0, rdy});
    check_eq("load_use", {31'd0, load_use}, {31'd0, lu});
    check_eq("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check_eq("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb[0];
        check_eq("A", out_a, e.use_pc ? e.pc : fwd(e.a1, e.d1));
        check_eq("B", out_b, e.use_imm ? e.imm : fwd(e.a2, e.d2));
        check_eq("store_data", store_data, fwd(e.a2, e.d2));
        check_eq("ALUop", {27'd0, aluop}, {27'd0, e.op});
        check_eq("rd", {27'd0, rd_addr}, {27'd0, e.rd});
        check_eq("ctrl", {29'd0, reg_write, mem_read, mem_write}, {29'd0, e.rw, e.mr, e.mw});
      end
    end else begin
      check_eq("ctrl_idle", {29'd0, reg_write, mem_read, mem_write}, 32'd0);
    end
`ifdef ID_EX_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, m_cnt);
`endif
    if (id_valid && !rdy && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (flush) begin
      m_valid = 1'b0;
      sb.delete();
    end else if (adv) begin
      sb.delete();
      if (lu) begin
        m_valid = 1'b0;
      end else if (id_valid) begin
        m_valid = 1'b1;
        m_rd = cur.rd;
        m_mr = cur.mr;
        sb.push_back(cur);
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    check_eq({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    check_eq({tag, "_A"}, out_a, 32'd0);
    check_eq({tag, "_B"}, out_b, 32'd0);
    check_eq({tag, "_store"}, store_data, 32'd0);
    check_eq({tag, "_op_rd"}, {22'd0, aluop, rd_addr}, 32'd0);
    check_eq({tag, "_ctrl"}, {28'd0, reg_write, mem_read, mem_write, load_use}, 32'd0);
    check_eq({tag, "_id_ready"}, {31'd0, id_ready}, 32'd0);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_mr = 1'b0;
    m_rd = '0;
    m_cnt = 0;
    sb.delete();
  endtask

  initial begin
    // Reset state, with decode offering an instruction that must not be accepted
    cur = mk(5'd1, 32'd5, 5'd2, 32'd7, 5'd9, 5'd3, 1'b0);
    id_valid = 1'b1;
    #12;
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    id_valid = 1'b0;
    model_reset();

    // Back-to-back adds
    cur = mk(5'd1, 32'd5, 5'd2, 32'd7, 5'd10, 5'h00, 1'b0);
    id_valid = 1'b1;
    cycle();
    check_eq("t1_A", out_a, 32'd5);
    check_eq("t1_B", out_b, 32'd7);
    check_eq("t1_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("t1_ready", {31'd0, id_ready}, 32'd1);
    cur = mk(5'd3, 32'd11, 5'd4, 32'd13, 5'd11, 5'h01, 1'b0);
    cycle();
    cur = mk(5'd5, 32'd17, 5'd6, 32'd19, 5'd12, 5'h02, 1'b0);
    cur.use_pc = 1'b1;
    cur.use_imm = 1'b1;
    cur.imm = 32'hFFFF_FFF0;
    cycle();
    id_valid = 1'b0;
    cycle();

    // Forwarding priority
    cur = mk(5'd3, 32'h33, 5'd5, 32'h55, 5'd6, 5'h02, 1'b0);
    id_valid = 1'b1;
    cycle();
    id_valid = 1'b0;
    ex_ready = 1'b0;
    mem_we = 1'b1; mem_rd = 5'd3; mem_res = 32'h11;
    wb_we = 1'b1;  wb_rd = 5'd3;  wb_res = 32'h22;
    #1 check_eq("t2_mem_wins", out_a, 32'h11);
    cycle();
    mem_we = 1'b0;
    #1 check_eq("t2_wb", out_a, 32'h22);
    cycle();
    mem_rd = 5'd5;
    mem_we = 1'b1;
    #1 check_eq("t2_rs2_store", store_data, 32'h11);
    cycle();
    mem_we = 1'b0; wb_we = 1'b0;
    ex_ready = 1'b1;
    cur = mk(5'd0, 32'h44, 5'd9, 32'h99, 5'd7, 5'h04, 1'b0);
    id_valid = 1'b1;
    cycle();
    id_valid = 1'b0;
    ex_ready = 1'b0;
    mem_we = 1'b1; mem_rd = 5'd0; mem_res = 32'hDEAD;
    wb_we = 1'b1;  wb_rd = 5'd0;  wb_res = 32'hBEEF;
    #1 check_eq("t2_x0", out_a, 32'h44);
    cycle();
    mem_we = 1'b0; wb_we = 1'b0;
    ex_ready = 1'b1;
    cycle();

    // Load-use: lw x4 followed by add using x4
    cur = mk(5'd1, 32'h1000, 5'd0, 32'd0, 5'd4, 5'h00, 1'b1);
    id_valid = 1'b1;
    cycle();
    cur = mk(5'd2, 32'd3, 5'd4, 32'd9, 5'd7, 5'h00, 1'b0);
    #1 check_eq("t3_lu", {31'd0, load_use}, 32'd1);
    check_eq("t3_ready", {31'd0, id_ready}, 32'd0);
    cycle();
    check_eq("t3_bubble", {31'd0, ex_valid}, 32'd0);
    check_eq("t3_ready2", {31'd0, id_ready}, 32'd1);
`ifdef ID_EX_STALL_CNT_EN
    check_eq("t3_cnt", stall_cnt, 32'd1);
`endif
    cycle();
    check_eq("t3_add", {31'd0, ex_valid}, 32'd1);
    id_valid = 1'b0;
    cycle();

    // Downstream stall for three cycles
    cur = mk(5'd1, 32'hA1, 5'd2, 32'hA2, 5'd8, 5'h05, 1'b0);
    id_valid = 1'b1;
    cycle();
    ex_ready = 1'b0;
    cur = mk(5'd3, 32'hB1, 5'd4, 32'hB2, 5'd9, 5'h06, 1'b0);
    repeat (3) cycle();
    check_eq("t4_frozen", out_a, 32'hA1);
    ex_ready = 1'b1;
    cycle();
    check_eq("t4_next", out_a, 32'hB1);
    id_valid = 1'b0;
    cycle();

    // Flush while stalled with a load-use hazard pending
    cur = mk(5'd1, 32'h2000, 5'd0, 32'd0, 5'd4, 5'h00, 1'b1);
    id_valid = 1'b1;
    cycle();
    ex_ready = 1'b0;
    flush = 1'b1;
    cur = mk(5'd4, 32'hC1, 5'd2, 32'hC2, 5'd5, 5'h07, 1'b0);
    #1 check_eq("t5_ready", {31'd0, id_ready}, 32'd1);
    cycle();
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    check_eq("t5_killed", {31'd0, ex_valid}, 32'd0);
    cycle();
    cycle();

    // Asynchronous reset while in the bubble
    cur = mk(5'd1, 32'h3000, 5'd0, 32'd0, 5'd4, 5'h00, 1'b1);
    id_valid = 1'b1;
    cycle();
    cur = mk(5'd4, 32'hD1, 5'd2, 32'hD2, 5'd5, 5'h08, 1'b0);
    cycle();
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("t6");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cur = mk(5'd6, 32'hE1, 5'd7, 32'hE2, 5'd3, 5'h09, 1'b0);
    cycle();
    check_eq("t6_latency", {31'd0, ex_valid}, 32'd1);
    check_eq("t6_A", out_a, 32'hE1);
    id_valid = 1'b0;
    cycle();

    // Random traffic with narrow register indices to provoke hazards and forwarding
    for (int i = 0; i < 300; i++) begin
      cur.pc      = $urandom;
      cur.imm     = $urandom;
      cur.d1      = $urandom;
      cur.d2      = $urandom;
      cur.a1      = 5'($urandom_range(0, 7));
      cur.a2      = 5'($urandom_range(0, 7));
      cur.rd      = 5'($urandom_range(0, 7));
      cur.op      = 5'($urandom_range(0, 31));
      cur.use_pc  = 1'($urandom_range(0, 1));
      cur.use_imm = 1'($urandom_range(0, 1));
      cur.rw      = 1'($urandom_range(0, 1));
      cur.mr      = 1'($urandom_range(0, 1));
      cur.mw      = 1'($urandom_range(0, 1));
      id_valid    = ($urandom_range(0, 3) != 0);
      ex_ready    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      mem_we      = 1'($urandom_range(0, 1));
      wb_we       = 1'($urandom_range(0, 1));
      mem_rd      = 5'($urandom_range(0, 7));
      wb_rd       = 5'($urandom_range(0, 7));
      mem_res     = $urandom;
      wb_res      = $urandom;
      cycle();
    end
    id_valid = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that registers one decoded instruction and presents its operands to the ALU: ov_A, ov_B and ov_ALUop feed the ALU's iv_A, iv_B and iv_ALUop. It resolves operand selection and MEM/WB result forwarding, and inserts a one-cycle bubble on load-use hazards. It applies valid/ready backpressure upstream toward decode and honours downstream stall and flush.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register-address width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  decode offers an instruction
- o_id_ready  out  1  stage accepts it this cycle
- iv_pc, iv_imm, iv_rs1_data, iv_rs2_data  in  XLEN each  decoded fields
- iv_rs1_addr, iv_rs2_addr, iv_rd_addr  in  RA_W each  register indices
- iv_ALUop  in  5  ALU operation code
- i_use_pc, i_use_imm, i_reg_write, i_mem_read, i_mem_write  in  1 each  control bits
- i_flush  in  1  kill held and incoming instruction
- i_ex_ready  in  1  downstream accepts held instruction
- iv_mem_rd_addr, iv_wb_rd_addr  in  RA_W  forwarding destinations
- iv_mem_result, iv_wb_result  in  XLEN  forwarding data
- i_mem_reg_write, i_wb_reg_write  in  1  forwarding enables
- o_ex_valid  out  1  held instruction valid
- ov_A, ov_B, ov_store_data  out  XLEN  ALU operands, store data
- ov_ALUop  out  5  held op code
- ov_rd_addr  out  RA_W; o_reg_write, o_mem_read, o_mem_write  out  1  held controls
- o_load_use  out  1  bubble being inserted this cycle
- ov_stall_cnt  out  32  stall counter (only with ID_EX_STALL_CNT_EN)

## Operation
- Held register: valid bit plus all decoded fields. On reset: valid=0 and every held field is 0. Consequently ov_A=ov_B=ov_store_data=0, ov_ALUop=0 (add), and all control outputs are 0.
- Advance condition: adv = !o_ex_valid | i_ex_ready.
- Load-use hazard: o_load_use = o_ex_valid & o_mem_read & i_id_valid & (iv_rd_addr_held != 0) & (held rd == iv_rs1_addr | held rd == iv_rs2_addr).
- Ready: o_id_ready = i_flush | (adv & !o_load_use).
- FSM states:
  - RUN: normal capture. If adv & o_load_use, load the bubble (valid=0, controls 0, data fields unchanged) and go to BUBBLE.
  - BUBBLE: lasts exactly one cycle and then returns to RUN. Capture rules in BUBBLE are the same as in RUN. The dependent instruction is captured here because the load is now in MEM.
- Capture on i_id_valid & o_id_ready & !i_flush. Writes valid=1 and all fields.
- If adv & !i_id_valid, valid clears to 0.
- If !adv, the register holds unchanged. This holds even when i_id_valid=1.
- Flush has priority over every other event. The next state is valid=0 and RUN, and the offered instruction is consumed and discarded.
- Forwarding (combinational on held rs1/rs2), priority order:
  1. MEM stage: i_mem_reg_write & iv_mem_rd_addr == rs & rs != 0.
  2. WB stage: same test with the wb_* inputs.
  3. Otherwise the held register data.
  - Register x0 always yields the held data.
- Operand selection:
  - ov_A = i_use_pc held ? pc : fwd(rs1).
  - ov_B = use_imm ? imm : fwd(rs2).
  - ov_store_data = fwd(rs2) always.
- Control outputs are gated by valid: o_reg_write, o_mem_read, o_mem_write = held & o_ex_valid.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs after edge N, i.e. in cycle N+1.
- Throughput: 1 instruction/cycle when there is no hazard and i_ex_ready=1.
- Load-use costs exactly one bubble cycle.
- o_id_ready, o_load_use and the forwarded operands are combinational within the cycle. There is no combinational path from i_id_valid to o_ex_valid.
- An asynchronous reset mid-stall drops the held instruction and the BUBBLE state immediately. While i_rst_n is low, o_id_ready=0.

## Configuration
- ID_EX_STALL_CNT_EN defined:
  - ov_stall_cnt is present.
  - It increments on each cycle with i_id_valid & !o_id_ready and saturates at 0xFFFF_FFFF.
  - Reset value is 0; flush does not clear it.
- ID_EX_STALL_CNT_EN undefined: the port and the counter are absent, and the rest of the behaviour is identical.

## Test plan
1. Back-to-back adds, i_ex_ready=1:
   - Stimulus: add rs1=x1 (5), rs2=x2 (7), ALUop 0x00.
   - Required: ov_A=5, ov_B=7, o_ex_valid=1 one cycle after accept; o_id_ready stays 1.
2. Forward priority:
   - Stimulus: held rs1=x3; MEM writes x3=0x11 and WB writes x3=0x22.
   - Required: ov_A=0x11.
   - Then drop the MEM write. Required: ov_A=0x22.
   - Then target x0. Required: the held data is used.
3. Load-use:
   - Stimulus: held lw rd=x4, incoming add rs2=x4.
   - Required: o_load_use=1 and o_id_ready=0 for one cycle; a bubble is issued (o_ex_valid=0); the add is captured the next cycle.
   - With the counter enabled, ov_stall_cnt=1.
4. Downstream stall:
   - Stimulus: i_ex_ready=0 for 3 cycles with i_id_valid=1.
   - Required: outputs are frozen and o_id_ready=0; on release, the next instruction is accepted.
5. Flush during stall:
   - Stimulus: i_flush=1 while i_ex_ready=0 and a load-use hazard is pending.
   - Required: o_id_ready=1; the next cycle o_ex_valid=0 with the FSM in RUN; the offered instruction is never output.
6. Reset mid-operation:
   - Stimulus: drop i_rst_n in BUBBLE.
   - Required: all outputs are 0 immediately; after release the first instruction has latency 1.
